interrupt_sequencer: RTL
========================

// Module: interrupt_sequencer
// PURPOSE
//  Arbitrates the 6502 interrupt sources (RESET, NMI, IRQ, BRK) at instruction boundaries.
//  Sequences the 7-cycle interrupt entry: opcode force, dummy read, three stack pushes, two vector reads.
//  Sits beside the instruction decoder and drives the opcode-force, stack-push and vector-fetch controls of the datapath.
// PARAMETERS
//  VECTOR_NMI  16'hFFFA  NMI vector low-byte address
//  VECTOR_RES  16'hFFFC  RESET vector low-byte address
//  VECTOR_IRQ  16'hFFFE  IRQ/BRK vector low-byte address
// PORTS
//  Clock        in   1   system clock; all state on rising edge
//  Reset_n      in   1   asynchronous, active-low reset
//  Phi_En       in   1   CPU cycle enable; state advances only when 1
//  Sync         in   1   opcode-fetch cycle (instruction boundary)
//  Brk_Decode   in   1   fetched opcode is BRK (00), valid with Sync
//  Irq_n        in   1   IRQ line, level-sensitive, active-low
//  Nmi_n        in   1   NMI line, falling-edge-sensitive
//  I_Flag       in   1   processor-status interrupt-disable bit
//  Force_Brk    out  1   replace fetched opcode with BRK, suppress PC increment
//  Int_Busy     out  1   sequence in progress (T1..T6)
//  Push_En      out  1   stack write this cycle
//  Stack_Sel    out  2   push source: 00 PCH, 01 PCL, 10 P
//  B_Flag       out  1   B bit value for pushed P
//  Vec_Rd       out  1   vector read this cycle
//  Vector_Addr  out  16  vector byte address, valid when Vec_Rd=1
//  Set_I        out  1   one-cycle pulse: set I flag
//  Int_Src      out  2   serviced source: 00 BRK, 01 IRQ, 10 NMI, 11 RES
// BEHAVIOUR
//  - Reset (Reset_n=0): FSM=IDLE, Res_Pending=1, Nmi_Pending=0, Nmi_Prev=1; every output 0 except Vector_Addr=VECTOR_RES and Int_Src=11.
//  - Nmi_Prev/Nmi_n sampled on Phi_En. Nmi_Prev=1 and Nmi_n=0 sets Nmi_Pending. Set wins over clear in the same cycle.
//    Nmi_n held low re-triggers nothing.
//  - IRQ request = ~Irq_n & ~I_Flag, evaluated combinationally at Sync; no latch.
//  - Boundary (IDLE, Sync & Phi_En): priority RES > NMI > IRQ > BRK.
//    RES/NMI/IRQ: Force_Brk=1 combinationally in this cycle; Brk_Decode is ignored.
//    BRK only: Force_Brk=0, Int_Src=00.
//    Nothing pending: stay IDLE.
//  - States, each advancing on Phi_En: IDLE -> T1 (dummy read) -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE.
//  - Push_En=1 in the PUSH_* states with the matching Stack_Sel. For RES, Push_En stays 0 (dummy stack reads).
//  - B_Flag=1 in PUSH_P only when Int_Src=00; otherwise 0.
//  - Vector base is latched on leaving PUSH_P: NMI -> VECTOR_NMI, RES -> VECTOR_RES, IRQ/BRK -> VECTOR_IRQ.
//    Vector_Addr = base in VEC_LO, base+1 in VEC_HI (16-bit wrap).
//  - Set_I=1 in VEC_LO.
//  - Nmi_Pending is cleared in VEC_LO when Int_Src=10. Res_Pending is cleared in VEC_LO when Int_Src=11.
//  - An NMI edge during VEC_LO/VEC_HI is held and serviced at the next boundary.
//  - Phi_En=0: FSM and outputs hold. Reset_n low mid-sequence aborts immediately to reset values.
//  - Int_Busy=1 in T1..VEC_HI. Latency: boundary to first vector read = 5 enabled cycles.
// CONFIGURATION
//  INT_SEQ_NMI_HIJACK_EN defined:
//    NMI edge latched while an IRQ/BRK sequence is in T1..PUSH_P switches Int_Src to 10 before the vector latch.
//    Result: VECTOR_NMI is fetched and Nmi_Pending is cleared. B_Flag is already driven from the original source
//    (BRK pushes B=1).
//  Undefined: the original vector is used; the NMI is serviced at the next boundary.
// STRUCTURE
//  Package int_seq_pkg: FSM state enum, Int_Src encodings, Stack_Sel encodings, default vector constants.
//  Sub-module nmi_edge_detect: Nmi_Prev/Nmi_Pending with set-priority clear input.
// TESTING
//  1 Release reset, Sync at first enabled cycle -> Force_Brk=1, Push_En never 1,
//    Vec_Rd at cycles 5/6 with Vector_Addr FFFC/FFFD, Set_I at FFFC.
//  2 Irq_n=0, I_Flag=0, Sync -> pushes PCH/PCL/P, B_Flag=0, vectors FFFE/FFFF.
//    Repeat with I_Flag=1 -> stays IDLE, Force_Brk=0.
//  3 Brk_Decode=1 at Sync, nothing pending -> Force_Brk=0, B_Flag=1 in PUSH_P, Int_Src=00, vectors FFFE/FFFF.
//  4 Nmi_n falls, then held low 100 cycles -> exactly one sequence, vectors FFFA/FFFB.
//    Nmi_n and Irq_n asserted together -> NMI first.
//  5 NMI edge during PUSH_PCL of an IRQ sequence:
//    with INT_SEQ_NMI_HIJACK_EN -> vectors FFFA/FFFB, no second sequence;
//    without -> FFFE/FFFF, then an NMI sequence at the next Sync.
//  6 Phi_En=0 for 10 cycles in PUSH_P -> outputs frozen.
//    Reset_n pulse in VEC_LO -> reset values at once, RES sequence at next Sync.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 interrupt sequencer: FSM states,
// serviced-source and stack-source encodings, and the default vector addresses.
package int_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T1       = 3'd1,
    ST_PUSH_PCH = 3'd2,
    ST_PUSH_PCL = 3'd3,
    ST_PUSH_P   = 3'd4,
    ST_VEC_LO   = 3'd5,
    ST_VEC_HI   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SRC_BRK = 2'b00,
    SRC_IRQ = 2'b01,
    SRC_NMI = 2'b10,
    SRC_RES = 2'b11
  } src_e;

  localparam logic [1:0] SEL_PCH = 2'b00;
  localparam logic [1:0] SEL_PCL = 2'b01;
  localparam logic [1:0] SEL_P   = 2'b10;

  localparam logic [15:0] VECTOR_NMI_DEFAULT = 16'hFFFA;
  localparam logic [15:0] VECTOR_RES_DEFAULT = 16'hFFFC;
  localparam logic [15:0] VECTOR_IRQ_DEFAULT = 16'hFFFE;

  function automatic logic [15:0] vector_base(input src_e src,
                                              input logic [15:0] vec_nmi,
                                              input logic [15:0] vec_res,
                                              input logic [15:0] vec_irq);
    case (src)
      SRC_NMI: return vec_nmi;
      SRC_RES: return vec_res;
      default: return vec_irq;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the NMI line, sampled on CPU cycle enables.
// A new edge sets the pending flag even when a clear is requested in the same cycle.
module nmi_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic phi_en_i,
  input  logic nmi_ni,
  input  logic clr_i,
  output logic pending_o
);

  logic prev_q;
  logic pending_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
    end else if (phi_en_i) begin
      prev_q <= nmi_ni;
      if (prev_q && !nmi_ni) begin
        pending_q <= 1'b1;
      end else if (clr_i) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt arbitration and 7-cycle entry sequencer (RES > NMI > IRQ > BRK).
// Define INT_SEQ_NMI_HIJACK_EN to let an NMI arriving in T1..PUSH_P take over an IRQ/BRK entry.
module interrupt_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [15:0] VECTOR_NMI = VECTOR_NMI_DEFAULT,
  parameter logic [15:0] VECTOR_RES = VECTOR_RES_DEFAULT,
  parameter logic [15:0] VECTOR_IRQ = VECTOR_IRQ_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        phi_en_i,
  input  logic        sync_i,
  input  logic        brk_decode_i,
  input  logic        irq_ni,
  input  logic        nmi_ni,
  input  logic        i_flag_i,
  output logic        force_brk_o,
  output logic        int_busy_o,
  output logic        push_en_o,
  output logic [1:0]  stack_sel_o,
  output logic        b_flag_o,
  output logic        vec_rd_o,
  output logic [15:0] vector_addr_o,
  output logic        set_i_o,
  output logic [1:0]  int_src_o
);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        brk_q, brk_d;
  logic [15:0] base_q, base_d;
  logic        res_pending_q, res_pending_d;
  logic        nmi_pending, nmi_clr, irq_req, force_brk;

  logic        busy_q, busy_d;
  logic        push_q, push_d;
  logic [1:0]  sel_q, sel_d;
  logic        bflag_q, bflag_d;
  logic        vrd_q, vrd_d;
  logic [15:0] vaddr_q, vaddr_d;
  logic        seti_q, seti_d;

  nmi_edge_detect u_nmi_edge (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .phi_en_i (phi_en_i),
    .nmi_ni   (nmi_ni),
    .clr_i    (nmi_clr),
    .pending_o(nmi_pending)
  );

  assign irq_req = !irq_ni && !i_flag_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    brk_d         = brk_q;
    base_d        = base_q;
    res_pending_d = res_pending_q;
    nmi_clr       = 1'b0;
    force_brk     = 1'b0;

    if (phi_en_i) begin
`ifdef INT_SEQ_NMI_HIJACK_EN
      if ((state_q inside {ST_T1, ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P}) && nmi_pending &&
          (src_q inside {SRC_BRK, SRC_IRQ})) begin
        src_d = SRC_NMI;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (sync_i) begin
            if (res_pending_q) begin
              src_d     = SRC_RES;
              force_brk = 1'b1;
            end else if (nmi_pending) begin
              src_d     = SRC_NMI;
              force_brk = 1'b1;
            end else if (irq_req) begin
              src_d     = SRC_IRQ;
              force_brk = 1'b1;
            end else if (brk_decode_i) begin
              src_d = SRC_BRK;
            end
            if (force_brk || brk_decode_i) begin
              state_d = ST_T1;
              brk_d   = !force_brk;
            end
          end
        end
        ST_T1:       state_d = ST_PUSH_PCH;
        ST_PUSH_PCH: state_d = ST_PUSH_PCL;
        ST_PUSH_PCL: state_d = ST_PUSH_P;
        ST_PUSH_P: begin
          state_d = ST_VEC_LO;
          base_d  = vector_base(src_d, VECTOR_NMI, VECTOR_RES, VECTOR_IRQ);
        end
        ST_VEC_LO: begin
          state_d = ST_VEC_HI;
          nmi_clr = (src_q == SRC_NMI);
          if (src_q == SRC_RES) res_pending_d = 1'b0;
        end
        ST_VEC_HI:   state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state and registered with it.
    busy_d  = (state_d != ST_IDLE);
    push_d  = (state_d inside {ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P}) && (src_d != SRC_RES);
    sel_d   = (state_d == ST_PUSH_PCL) ? SEL_PCL :
              (state_d == ST_PUSH_P)   ? SEL_P   : SEL_PCH;
    bflag_d = (state_d == ST_PUSH_P) && brk_d;
    vrd_d   = (state_d inside {ST_VEC_LO, ST_VEC_HI});
    seti_d  = (state_d == ST_VEC_LO);
    vaddr_d = (state_d == ST_VEC_LO) ? base_d :
              (state_d == ST_VEC_HI) ? base_d + 16'd1 : vaddr_q;
  end

  // NOTE: the asynchronous reset drops the sequencer back to its idle/RES-pending
  // state immediately, even mid-sequence and without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_RES;
      brk_q         <= 1'b0;
      base_q        <= VECTOR_RES;
      res_pending_q <= 1'b1;
      busy_q        <= 1'b0;
      push_q        <= 1'b0;
      sel_q         <= SEL_PCH;
      bflag_q       <= 1'b0;
      vrd_q         <= 1'b0;
      vaddr_q       <= VECTOR_RES;
      seti_q        <= 1'b0;
    end else if (phi_en_i) begin
      state_q       <= state_d;
      src_q         <= src_d;
      brk_q         <= brk_d;
      base_q        <= base_d;
      res_pending_q <= res_pending_d;
      busy_q        <= busy_d;
      push_q        <= push_d;
      sel_q         <= sel_d;
      bflag_q       <= bflag_d;
      vrd_q         <= vrd_d;
      vaddr_q       <= vaddr_d;
      seti_q        <= seti_d;
    end
  end

  assign force_brk_o   = force_brk;
  assign int_busy_o    = busy_q;
  assign push_en_o     = push_q;
  assign stack_sel_o   = sel_q;
  assign b_flag_o      = bflag_q;
  assign vec_rd_o      = vrd_q;
  assign vector_addr_o = vaddr_q;
  assign set_i_o       = seti_q;
  assign int_src_o     = src_q;

endmodule
